core_timer_mc: RTL and testbench

//  Multi-channel machine timer, parametrised successor of the single-compare core timer. One 64-bit

---
 rtl/core_timer_mc.sv | 181 ++++++++++++++++++
 tb/tb_core_timer_mc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_timer_mc.sv
// core_timer_mc: multi-channel machine timer behind a reg-bus slave port.
// One 64-bit mtime counter with a programmable prescaler and NUM_CH
// independent 64-bit compare channels. Each channel has sticky pending and
// enable bits and drives its own registered interrupt output.
// Optional build macro CORE_TIMER_SNAPSHOT_EN: a read of MTIME_L latches
// mtime[63:32] into a shadow, and MTIME_H reads return that shadow. This
// gives a tear-free L-then-H 64-bit read.
module core_timer_mc #(
  parameter int NUM_CH  = 4,
  parameter int PRESC_W = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              valid_reg_access,
  input  logic [15:0]       addr,
  input  logic              rd_wr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic [NUM_CH-1:0] timer_int
);

  localparam logic [15:0] A_MTIME_L  = 16'h0000;
  localparam logic [15:0] A_MTIME_H  = 16'h0004;
  localparam logic [15:0] A_CTRL     = 16'h0008;
  localparam logic [15:0] A_PEND     = 16'h000C;
  localparam logic [15:0] A_EN       = 16'h0010;
  localparam logic [15:0] A_CMP_BASE = 16'h0020;

  logic               wr_acc, rd_acc;
  logic               wr_mtime_l, wr_mtime_h, wr_ctrl, wr_pend, wr_inten;
  logic [NUM_CH-1:0]  wr_cmp_l, wr_cmp_h;

  logic [63:0]        mtime;
  logic               run;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;
  logic [NUM_CH-1:0]  int_pend, int_en;
  logic [31:0]        cmp_l [NUM_CH];
  logic [31:0]        cmp_h [NUM_CH];
  logic [NUM_CH-1:0]  match, pend_nxt, en_nxt;
  logic [31:0]        mtime_h_rd;

  assign wr_acc     = valid_reg_access & rd_wr;
  assign rd_acc     = valid_reg_access & ~rd_wr;
  assign wr_mtime_l = wr_acc & (addr == A_MTIME_L);
  assign wr_mtime_h = wr_acc & (addr == A_MTIME_H);
  assign wr_ctrl    = wr_acc & (addr == A_CTRL);
  assign wr_pend    = wr_acc & (addr == A_PEND);
  assign wr_inten   = wr_acc & (addr == A_EN);

  // A tick fires on the last cycle of each prescaler period.
  assign tick = run & (presc_cnt == presc);

  // Per-channel compare write strobes.
  always_comb begin
    wr_cmp_l = '0;
    wr_cmp_h = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_cmp_l[i] = wr_acc & (addr == A_CMP_BASE + 16'(8 * i));
      wr_cmp_h[i] = wr_acc & (addr == A_CMP_BASE + 16'(8 * i + 4));
    end
  end

  // The match compare uses the current registers. The pending-bit priority is:
  // a compare write clears the bit, then a match sets it, then W1C clears it.
  always_comb begin
    match    = '0;
    pend_nxt = int_pend;
    for (int i = 0; i < NUM_CH; i++) begin
      match[i] = ({cmp_h[i], cmp_l[i]} <= mtime);
      if (wr_cmp_l[i] | wr_cmp_h[i])
        pend_nxt[i] = 1'b0;
      else if (match[i])
        pend_nxt[i] = 1'b1;
      else if (wr_pend & write_data[i])
        pend_nxt[i] = 1'b0;
    end
    en_nxt = wr_inten ? write_data[NUM_CH-1:0] : int_en;
  end

  // mtime counter: a software write to either half wins over the tick.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      mtime <= '0;
    else if (wr_mtime_l)
      mtime[31:0] <= write_data;
    else if (wr_mtime_h)
      mtime[63:32] <= write_data;
    else if (tick)
      mtime <= mtime + 64'd1;
  end

  // CTRL register and prescaler count. A CTRL write restarts the period.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      run       <= 1'b0;
      presc     <= '0;
      presc_cnt <= '0;
    end else begin
      if (wr_ctrl) begin
        run   <= write_data[0];
        presc <= write_data[8 +: PRESC_W];
      end
      if (wr_ctrl || !run || tick)
        presc_cnt <= '0;
      else
        presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  // Compare value registers. They reset to all ones, so nothing matches early.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_l[i] <= '1;
        cmp_h[i] <= '1;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_cmp_l[i]) cmp_l[i] <= write_data;
        if (wr_cmp_h[i]) cmp_h[i] <= write_data;
      end
    end
  end

  // Pending and enable bits. The interrupt is computed from their next values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      int_pend  <= '0;
      int_en    <= '0;
      timer_int <= '0;
    end else begin
      int_pend  <= pend_nxt;
      int_en    <= en_nxt;
      timer_int <= pend_nxt & en_nxt;
    end
  end

`ifdef CORE_TIMER_SNAPSHOT_EN
  logic [31:0] mtime_h_shadow;

  // Upper-half shadow: captured on an MTIME_L read and kept coherent on an MTIME_H write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      mtime_h_shadow <= '0;
    else if (wr_mtime_h)
      mtime_h_shadow <= write_data;
    else if (rd_acc && (addr == A_MTIME_L))
      mtime_h_shadow <= mtime[63:32];
  end

  assign mtime_h_rd = mtime_h_shadow;
`else
  assign mtime_h_rd = mtime[63:32];
`endif

  // Combinational read mux. Idle cycles and unmapped addresses return zero.
  always_comb begin
    read_data = '0;
    if (rd_acc) begin
      case (addr)
        A_MTIME_L: read_data = mtime[31:0];
        A_MTIME_H: read_data = mtime_h_rd;
        A_CTRL: begin
          read_data[0]            = run;
          read_data[8 +: PRESC_W] = presc;
        end
        A_PEND:    read_data[NUM_CH-1:0] = int_pend;
        A_EN:      read_data[NUM_CH-1:0] = int_en;
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (addr == A_CMP_BASE + 16'(8 * i))     read_data = cmp_l[i];
            if (addr == A_CMP_BASE + 16'(8 * i + 4)) read_data = cmp_h[i];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_timer_mc.sv
// Testbench for core_timer_mc: directed register traffic, with a register-level reference model
// checked on every cycle, plus hand-computed literal expectations.
module tb_core_timer_mc;

  localparam int NUM_CH  = 4;
  localparam int PRESC_W = 8;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              valid_reg_access;
  logic [15:0]       addr;
  logic              rd_wr;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic [NUM_CH-1:0] timer_int;

  int vectors     = 0;
  int miscompares = 0;

  core_timer_mc #(.NUM_CH(NUM_CH), .PRESC_W(PRESC_W)) dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .valid_reg_access (valid_reg_access),
    .addr             (addr),
    .rd_wr            (rd_wr),
    .write_data       (write_data),
    .read_data        (read_data),
    .timer_int        (timer_int)
  );

  always #5 HCLK = ~HCLK;

  // ---------------- reference model (register-level view) ----------------
  logic [63:0]        m_mtime;
  logic               m_run;
  logic [PRESC_W-1:0] m_presc;
  int                 m_since_tick;   // cycles elapsed in the current prescaler period
  logic [NUM_CH-1:0]  m_pend, m_en, m_tint;
  logic [63:0]        m_cmp [NUM_CH];
  logic [31:0]        m_shadow;

  function automatic bit is_cmp(input logic [15:0] a);
    return (a >= 16'h20) && (a < 16'h20 + 16'(8 * NUM_CH)) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a);
    logic [31:0] r;
    int idx;
    r = 32'h0;
    if (a == 16'h0000) r = m_mtime[31:0];
    else if (a == 16'h0004) begin
`ifdef CORE_TIMER_SNAPSHOT_EN
      r = m_shadow;
`else
      r = m_mtime[63:32];
`endif
    end
    else if (a == 16'h0008) r = {16'h0, m_presc, 7'h0, m_run};
    else if (a == 16'h000C) r = 32'(m_pend);
    else if (a == 16'h0010) r = 32'(m_en);
    else if (is_cmp(a)) begin
      idx = (int'(a) - 32) / 8;
      r = a[2] ? m_cmp[idx][63:32] : m_cmp[idx][31:0];
    end
    return r;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin : model
    logic wr, rd, tick;
    logic [63:0] mt_nx;
    logic [NUM_CH-1:0] pend_nx, en_nx, cleared;
    int idx;
    if (!HRESETn) begin
      m_mtime = 64'h0; m_run = 1'b0; m_presc = '0; m_since_tick = 0;
      m_pend = '0; m_en = '0; m_tint = '0; m_shadow = 32'h0;
      for (int i = 0; i < NUM_CH; i++) m_cmp[i] = {64{1'b1}};
    end else begin
      wr = valid_reg_access && rd_wr;
      rd = valid_reg_access && !rd_wr;
      tick = m_run && (m_since_tick == int'(m_presc));
      // pending bits from the old counter and compare values
      pend_nx = m_pend;
      cleared = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_mtime >= m_cmp[i]) pend_nx[i] = 1'b1;
        else if (wr && addr == 16'h000C && write_data[i]) pend_nx[i] = 1'b0;
      end
      if (wr && is_cmp(addr)) begin
        idx = (int'(addr) - 32) / 8;
        cleared[idx] = 1'b1;
        if (addr[2]) m_cmp[idx][63:32] = write_data;
        else         m_cmp[idx][31:0]  = write_data;
      end
      pend_nx = pend_nx & ~cleared;
      en_nx = (wr && addr == 16'h0010) ? write_data[NUM_CH-1:0] : m_en;
      // counter
      mt_nx = tick ? m_mtime + 64'd1 : m_mtime;
      if (wr && addr == 16'h0000) mt_nx = {m_mtime[63:32], write_data};
      if (wr && addr == 16'h0004) mt_nx = {write_data, m_mtime[31:0]};
      // shadow of the upper half
      if (wr && addr == 16'h0004) m_shadow = write_data;
      else if (rd && addr == 16'h0000) m_shadow = m_mtime[63:32];
      // prescaler period
      if ((wr && addr == 16'h0008) || !m_run || tick) m_since_tick = 0;
      else m_since_tick = m_since_tick + 1;
      if (wr && addr == 16'h0008) begin
        m_run   = write_data[0];
        m_presc = write_data[8 +: PRESC_W];
      end
      m_mtime = mt_nx;
      m_pend  = pend_nx;
      m_en    = en_nx;
      m_tint  = pend_nx & en_nx;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, sampled on the falling edge.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      check32("model_timer_int", 32'(timer_int), 32'(m_tint));
      if (valid_reg_access && !rd_wr)
        check32("model_read_data", read_data, m_read(addr));
      else
        check32("idle_read_data", read_data, 32'h0);
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    valid_reg_access = 1'b1; rd_wr = 1'b1; addr = a; write_data = d;
    @(posedge HCLK); #1;
    valid_reg_access = 1'b0; rd_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [31:0] exp, input string name);
    valid_reg_access = 1'b1; rd_wr = 1'b0; addr = a;
    @(negedge HCLK);
    check32(name, read_data, exp);
    @(posedge HCLK); #1;
    valid_reg_access = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  initial begin
    int n;
    HRESETn = 1'b0; valid_reg_access = 1'b0; rd_wr = 1'b0; addr = '0; write_data = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // reset state
    check32("rst_timer_int", 32'(timer_int), 32'h0);
    bus_read(16'h00, 32'h0, "rst_mtime_l");
    bus_read(16'h04, 32'h0, "rst_mtime_h");
    bus_read(16'h08, 32'h0, "rst_ctrl");
    bus_read(16'h0C, 32'h0, "rst_pend");
    bus_read(16'h10, 32'h0, "rst_en");
    for (int i = 0; i < NUM_CH; i++) begin
      bus_read(16'h20 + 16'(8 * i), 32'hFFFF_FFFF, "rst_cmp_l");
      bus_read(16'h24 + 16'(8 * i), 32'hFFFF_FFFF, "rst_cmp_h");
    end
    bus_read(16'h14, 32'h0, "unmapped_14");
    bus_read(16'h40, 32'h0, "unmapped_40");
    bus_write(16'h14, 32'hDEAD_BEEF);
    bus_read(16'h14, 32'h0, "unmapped_write_ignored");

    // prescaler 3: one tick every 4 cycles; run=0 freezes
    bus_write(16'h08, 32'h0000_0301);
    bus_read(16'h08, 32'h0000_0301, "ctrl_readback");
    idle(7);
    bus_read(16'h00, 32'h2, "presc3_two_ticks");
    bus_write(16'h08, 32'h0);
    idle(10);
    bus_read(16'h00, 32'h2, "stopped_frozen");

    // channel 0 compare at 0x10, presc 0
    bus_write(16'h20, 32'h10);
    bus_write(16'h24, 32'h0);
    bus_write(16'h10, 32'h1);
    bus_write(16'h00, 32'h0);
    bus_write(16'h04, 32'h0);
    bus_write(16'h08, 32'h1);
    n = 0;
    while (timer_int[0] !== 1'b1 && n < 40) begin idle(1); n++; end
    check32("cmp0_int_latency", 32'(n), 32'd17);
    bus_read(16'h0C, 32'h1, "cmp0_pending");
    bus_write(16'h0C, 32'h1);
    bus_read(16'h0C, 32'h1, "w1c_while_match_stays");
    bus_write(16'h20, 32'h100);
    check32("cmp_write_drops_int", 32'(timer_int), 32'h0);
    bus_read(16'h0C, 32'h0, "cmp_write_clears_pend");
    bus_write(16'h08, 32'h0);

    // wrap of the 64-bit counter
    bus_write(16'h04, 32'hFFFF_FFFF);
    bus_write(16'h00, 32'hFFFF_FFFE);
    bus_write(16'h28, 32'h5);
    bus_write(16'h2C, 32'h0);
    bus_write(16'h08, 32'h1);
    idle(1);
    bus_write(16'h08, 32'h0);
    bus_read(16'h00, 32'h0, "wrap_mtime_l");
    bus_read(16'h04, 32'h0, "wrap_mtime_h");
    bus_read(16'h0C, 32'hF, "pend_survives_wrap");
    bus_write(16'h0C, 32'hF);
    bus_read(16'h0C, 32'h0, "w1c_after_wrap");

    // two channels matching together, only channel 1 enabled
    bus_write(16'h20, 32'h8);
    bus_write(16'h28, 32'h8);
    bus_write(16'h10, 32'h2);
    bus_write(16'h08, 32'h1);
    n = 0;
    while (timer_int === '0 && n < 40) begin idle(1); n++; end
    check32("dual_match_latency", 32'(n), 32'd9);
    check32("dual_match_int", 32'(timer_int), 32'h2);
    bus_read(16'h0C, 32'h3, "dual_match_pend");
    bus_write(16'h28, 32'h4);
    check32("cmp_write_beats_match_int", 32'(timer_int), 32'h0);
    bus_read(16'h0C, 32'h1, "cmp_write_beats_match_pend");
    bus_write(16'h08, 32'h0);
    bus_write(16'h10, 32'h3);
    check32("en_change_int", 32'(timer_int), 32'h3);
    bus_write(16'h10, 32'h2);
    check32("en_restore_int", 32'(timer_int), 32'h2);

    // carry between the halves: L read before the carry, H read after it
    bus_write(16'h04, 32'h0);
    bus_write(16'h00, 32'hFFFF_FFFF);
    bus_read(16'h00, 32'hFFFF_FFFF, "pre_carry_l");
    bus_write(16'h08, 32'h1);
    bus_write(16'h08, 32'h0);
`ifdef CORE_TIMER_SNAPSHOT_EN
    bus_read(16'h04, 32'h0, "snapshot_h_after_carry");
`else
    bus_read(16'h04, 32'h1, "live_h_after_carry");
`endif
    bus_read(16'h00, 32'h0, "post_carry_l");
    bus_read(16'h04, 32'h1, "post_carry_h");

    // asynchronous reset in the middle of a cycle
    check32("pre_reset_int", 32'(timer_int), 32'h2);
    @(posedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    check32("async_reset_int", 32'(timer_int), 32'h0);
    bus_read(16'h04, 32'h0, "in_reset_mtime_h");
    HRESETn = 1'b1;
    bus_read(16'h08, 32'h0, "post_reset_ctrl");
    bus_read(16'h0C, 32'h0, "post_reset_pend");
    bus_read(16'h20, 32'hFFFF_FFFF, "post_reset_cmp_l0");
    bus_read(16'h00, 32'h0, "post_reset_mtime_l");
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
